// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] PC_INC   = 32'd4;

  // A redirect target is usable only when it is word aligned.
  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding {pc, inst} pairs between fetch and decode.
// Storage is not reset; only pointers and count are, so stale words are never
// visible because the count gates them.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           rdata
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign rdata = mem[rd_ptr];

  // Pointer and occupancy tracking; flush empties the queue in one edge.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage write at the tail.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory word
// address, queues fetched {pc, inst} pairs and hands the head to decode.
// Redirects from execute flush the queue and reload the PC; a misaligned
// target raises a sticky fault that halts fetching until reset.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int          FQ_DEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_inst,
  output logic [31:0]       dec_pc,
  output logic              fetch_fault
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  logic [XLEN-1:0]   pc;
  logic [CNT_W-1:0]  count;
  logic [63:0]       head;
  logic              pop;
  logic              push;

  assign imem_addr = pc[ADDR_W+1:2];

  // Head is valid whenever the queue holds anything; outputs depend only on
  // registered state so decode handshake and redirect never reach them combinationally.
  assign dec_valid = (count != '0);
  assign dec_inst  = dec_valid ? head[31:0]  : NOP_INST;
  assign dec_pc    = dec_valid ? head[63:32] : '0;

  assign pop  = dec_valid & dec_ready & ~redirect_valid;
  assign push = ~redirect_valid & ~fetch_fault & ((count < DEPTH_C) | pop);

  // PC and sticky fault: redirect wins over sequential advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
      if (is_misaligned(redirect_pc)) fetch_fault <= 1'b1;
    end else if (push) begin
      pc <= pc + PC_INC;
    end
  end

  fetch_queue #(
    .WIDTH (64),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({pc, imem_data}),
    .count (count),
    .rdata (head)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios against fixed expectations plus a
// randomized run against a queue-based reference model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        fetch_fault;

  logic [31:0] mem [64];
  assign imem_data = mem[imem_addr];

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [63:0] m_q [$];
  logic [31:0] m_pc;
  logic        m_fault;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .fetch_fault    (fetch_fault)
  );

  // Reference model: apply one clock edge using the fetch rules directly.
  task automatic model_edge(input logic rstn, input logic rv,
                            input logic [31:0] rpc, input logic rdy);
    logic do_pop, do_push;
    if (!rstn) begin
      m_q.delete();
      m_pc    = 32'h0;
      m_fault = 1'b0;
    end else if (rv) begin
      m_q.delete();
      m_pc = rpc;
      if (rpc[1:0] != 2'b00) m_fault = 1'b1;
    end else begin
      do_pop  = (m_q.size() != 0) && rdy;
      do_push = !m_fault && ((m_q.size() < 2) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        m_q.push_back({m_pc, mem[m_pc[7:2]]});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample at the falling edge.
  task automatic cyc(input logic rstn, input logic rv,
                     input logic [31:0] rpc, input logic rdy);
    rst_n          = rstn;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_ready      = rdy;
    model_edge(rstn, rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", dec_valid); end
    checks++; if (dec_inst !== NOP) begin errors++; $display("FAIL reset_inst got=%h exp=%h", dec_inst, NOP); end
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", dec_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%0b exp=0", fetch_fault); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%0b exp=1", i, dec_valid); end
      checks++; if (dec_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, dec_pc, 4 * i); end
      checks++; if (dec_inst !== mem[i]) begin errors++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, dec_inst, mem[i]); end
    end
  endtask

  task automatic test_stall();
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b0);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_inst !== mem[0]) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%0b pc=%h inst=%h exp v=1 pc=0 inst=%h", i, dec_valid, dec_pc, dec_inst, mem[0]);
      end
    end
    checks++; if (imem_addr !== 6'd2) begin errors++; $display("FAIL stall_addr got=%0d exp=2", imem_addr); end
    for (int i = 1; i < 4; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(4 * i) || dec_inst !== mem[i]) begin
        errors++; $display("FAIL stall_release[%0d] got v=%0b pc=%h inst=%h exp pc=%h inst=%h", i, dec_valid, dec_pc, dec_inst, 4 * i, mem[i]);
      end
    end
  endtask

  task automatic test_redirect();
    cyc(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h20, 1'b1);
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got=%0b exp=0", dec_valid); end
    checks++; if (imem_addr !== 6'd8) begin errors++; $display("FAIL redir_addr got=%0d exp=8", imem_addr); end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'(32'h20 + 4 * i) || dec_inst !== mem[8 + i]) begin
        errors++; $display("FAIL redir_target[%0d] got v=%0b pc=%h inst=%h exp pc=%h inst=%h", i, dec_valid, dec_pc, dec_inst, 32'h20 + 4 * i, mem[8 + i]);
      end
    end
  endtask

  task automatic test_misaligned();
    cyc(1'b1, 1'b1, 32'h22, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (fetch_fault !== 1'b1 || dec_valid !== 1'b0 || imem_addr !== 6'd8 || dec_inst !== NOP || dec_pc !== 32'h0) begin
        errors++; $display("FAIL misalign[%0d] got f=%0b v=%0b addr=%0d inst=%h pc=%h exp f=1 v=0 addr=8", i, fetch_fault, dec_valid, imem_addr, dec_inst, dec_pc);
      end
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
    end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (fetch_fault !== 1'b0 || dec_pc !== 32'h0 || dec_valid !== 1'b0) begin
      errors++; $display("FAIL misalign_clear got f=%0b pc=%h v=%0b exp f=0 pc=0 v=0", fetch_fault, dec_pc, dec_valid);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [5:0]  exp_addr [3];
    exp_pc[0] = 32'hFC;  exp_pc[1] = 32'h100; exp_pc[2] = 32'h104;
    exp_addr[0] = 6'd63; exp_addr[1] = 6'd0;  exp_addr[2] = 6'd1;
    cyc(1'b1, 1'b1, 32'hFC, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_addr !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr[%0d] got=%0d exp=%0d", i, imem_addr, exp_addr[i]); end
      cyc(1'b1, 1'b0, 32'h0, 1'b1);
      checks++; if (dec_valid !== 1'b1 || dec_pc !== exp_pc[i] || dec_inst !== mem[exp_addr[i]]) begin
        errors++; $display("FAIL wrap_head[%0d] got v=%0b pc=%h inst=%h exp pc=%h inst=%h", i, dec_valid, dec_pc, dec_inst, exp_pc[i], mem[exp_addr[i]]);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got=%0b exp=1", dec_valid); end
    cyc(1'b0, 1'b0, 32'h0, 1'b1);
    checks++; if (dec_valid !== 1'b0 || dec_inst !== NOP || dec_pc !== 32'h0) begin
      errors++; $display("FAIL mid_reset got v=%0b inst=%h pc=%h exp v=0 inst=%h pc=0", dec_valid, dec_inst, dec_pc, NOP);
    end
    cyc(1'b1, 1'b0, 32'h0, 1'b1);
    checks++; if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_inst !== mem[0]) begin
      errors++; $display("FAIL mid_resume got v=%0b pc=%h inst=%h exp pc=0 inst=%h", dec_valid, dec_pc, dec_inst, mem[0]);
    end
  endtask

  task automatic test_random();
    logic        rstn, rv, rdy;
    logic [31:0] rpc;
    logic        e_v;
    logic [31:0] e_inst, e_pc;
    for (int n = 0; n < 400; n++) begin
      rstn = ($urandom_range(0, 39) != 0);
      rv   = ($urandom_range(0, 9) == 0);
      rpc  = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      rdy  = ($urandom_range(0, 2) != 0);
      cyc(rstn, rv, rpc, rdy);
      e_v    = (m_q.size() != 0);
      e_inst = e_v ? m_q[0][31:0]  : NOP;
      e_pc   = e_v ? m_q[0][63:32] : 32'h0;
      checks++; if (dec_valid !== e_v || dec_inst !== e_inst || dec_pc !== e_pc ||
                    fetch_fault !== m_fault || imem_addr !== m_pc[7:2]) begin
        errors++; $display("FAIL random[%0d] got v=%0b inst=%h pc=%h f=%0b addr=%0d exp v=%0b inst=%h pc=%h f=%0b addr=%0d",
                           n, dec_valid, dec_inst, dec_pc, fetch_fault, imem_addr, e_v, e_inst, e_pc, m_fault, m_pc[7:2]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    m_pc = 32'h0; m_fault = 1'b0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
